// File: rtl/dram_port_arbiter_if.sv
// Bundle of CPU MEM-stage, DMA requester and RAM macro signals around the
// data-RAM port arbiter. The arbiter takes the slave view; requesters and the
// RAM model take the master view.
interface dram_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  // CPU MEM stage
  logic              cpu_req;
  logic              cpu_wmem;
  logic [31:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  // DMA / debug requester
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  // RAM macro
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  cpu_req, cpu_wmem, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output ram_addr, ram_wdata, ram_we,
    input  ram_q
  );

  modport master (
    output cpu_req, cpu_wmem, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  ram_addr, ram_wdata, ram_we,
    output ram_q
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// Arbiter sharing the single-port data RAM between the CPU MEM stage (primary)
// and a DMA/debug requester (secondary). The CPU wins by default; a DMA request
// denied MAX_WAIT consecutive cycles is forced through, stalling the CPU for
// that one cycle. CPU I/O accesses (addr[7]=1) never touch the RAM.
module dram_port_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                mem_clock,
  input  logic                resetn,
  dram_port_arbiter_if.slave  bus
);

  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  logic              cpu_ram;
  logic              dma_win;
  logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_wdata_c;
  logic              ram_we_c;
  logic              unused_addr_bits;

  // Only cpu_addr[ADDR_W+1:2] and bit 7 select anything; the rest is folded here.
  assign unused_addr_bits = ^bus.cpu_addr;

  // Per-cycle grant decision
  always_comb begin
    cpu_ram = bus.cpu_req & ~bus.cpu_addr[7];
    dma_win = bus.dma_req & (~cpu_ram | (wait_cnt_q == WAIT_MAX));
  end

  // RAM port mux: DMA winner, else CPU RAM access, else idle read following CPU
  always_comb begin
    ram_addr_c  = bus.cpu_addr[ADDR_W+1:2];
    ram_wdata_c = bus.cpu_wdata;
    ram_we_c    = 1'b0;
    if (dma_win) begin
      ram_addr_c  = bus.dma_addr;
      ram_wdata_c = bus.dma_wdata;
      ram_we_c    = bus.dma_we;
    end else if (cpu_ram) begin
      ram_we_c    = bus.cpu_wmem;
    end
  end

  // Next-state for starvation counter and DMA read-return pipeline
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.dma_req || dma_win) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    rd_pend_d   = dma_win & ~bus.dma_we;
    dma_rdata_d = rd_pend_q ? bus.ram_q : dma_rdata_q;
  end

  // State registers
  always_ff @(posedge mem_clock or negedge resetn) begin
    if (!resetn) begin
      wait_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      dma_rdata_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      rd_pend_q   <= rd_pend_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign bus.ram_addr   = ram_addr_c;
  assign bus.ram_wdata  = ram_wdata_c;
  // Write enable is gated by reset so no RAM write can occur while resetn is low.
  assign bus.ram_we     = ram_we_c & resetn;
  assign bus.dma_gnt    = dma_win;
  assign bus.cpu_stall  = cpu_ram & dma_win;
  assign bus.cpu_rdata  = bus.ram_q;
  assign bus.dma_rvalid = rd_pend_q;
  // Read data is forwarded straight from the RAM in the return cycle, then held.
  assign bus.dma_rdata  = rd_pend_q ? bus.ram_q : dma_rdata_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (forced DMA slot, withdrawn
// request, reset during a pending DMA read). Includes a 32-word RAM model.
module tb_dram_port_arbiter;

  logic mem_clock;
  logic resetn;
  int   n_chk;
  int   n_fail;
  int   n;

  dram_port_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  dram_port_arbiter #(.ADDR_W(5), .DATA_W(32), .MAX_WAIT(4)) dut (
    .mem_clock (mem_clock),
    .resetn    (resetn),
    .bus       (bus)
  );

  initial mem_clock = 1'b0;
  always #5 mem_clock = ~mem_clock;

  // RAM macro model: synchronous write, registered read (old data on collision)
  logic [31:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = '0;
  always @(posedge mem_clock) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_q <= mem[bus.ram_addr];
  end

  typedef struct {
    logic        cpu_req;
    logic        cpu_wmem;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        dma_req;
    logic        dma_we;
    logic [4:0]  dma_addr;
    logic [31:0] dma_wdata;
    logic        e_gnt;
    logic        e_stall;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_rdchk;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic creq, input logic cwm, input logic [31:0] ca,
                       input logic [31:0] cwd, input logic dreq, input logic dwe,
                       input logic [4:0] da, input logic [31:0] dwd);
    bus.cpu_req   = creq;
    bus.cpu_wmem  = cwm;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cwd;
    bus.dma_req   = dreq;
    bus.dma_we    = dwe;
    bus.dma_addr  = da;
    bus.dma_wdata = dwd;
  endtask

  // Runs cycles with the current inputs until dma_gnt, returning the 0-based
  // cycle index (-1 on timeout). Returns at the falling edge of the grant cycle.
  task automatic run_to_gnt(input string tag, output int idx);
    idx = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge mem_clock);
      if (bus.dma_gnt) begin
        idx = c;
        chk({tag, "_stall_on_gnt"}, bus.cpu_stall, 1'b1);
        break;
      end
      chk({tag, "_stall_while_denied"}, bus.cpu_stall, 1'b0);
      @(posedge mem_clock); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;

    //          creq cwm addr      cwdata        dreq dwe da  dwdata        gnt stl we ea  ewdata        rdchk rdata
    vecs[0] = '{1'b1,1'b1,32'h10,32'hCAFEBABE, 1'b0,1'b0,5'd0,32'h0,      1'b0,1'b0,1'b1,5'd4, 32'hCAFEBABE,1'b0,32'h0};
    vecs[1] = '{1'b0,1'b0,32'h0, 32'h0,        1'b1,1'b1,5'd7,32'h1234,   1'b1,1'b0,1'b1,5'd7, 32'h1234,    1'b0,32'h0};
    vecs[2] = '{1'b0,1'b0,32'h0, 32'h0,        1'b1,1'b1,5'd3,32'hA5A5,   1'b1,1'b0,1'b1,5'd3, 32'hA5A5,    1'b0,32'h0};
    vecs[3] = '{1'b1,1'b1,32'h80,32'h55,       1'b1,1'b1,5'd9,32'hBEEF,   1'b1,1'b0,1'b1,5'd9, 32'hBEEF,    1'b0,32'h0};
    vecs[4] = '{1'b1,1'b0,32'h0C,32'h0,        1'b0,1'b0,5'd0,32'h0,      1'b0,1'b0,1'b0,5'd3, 32'h0,       1'b0,32'h0};
    vecs[5] = '{1'b1,1'b0,32'h0C,32'h11,       1'b1,1'b0,5'd3,32'h0,      1'b0,1'b0,1'b0,5'd3, 32'h11,      1'b1,32'hA5A5};
    vecs[6] = '{1'b0,1'b0,32'h7C,32'h77,       1'b0,1'b0,5'd0,32'h0,      1'b0,1'b0,1'b0,5'd31,32'h77,      1'b0,32'h0};
    vecs[7] = '{1'b1,1'b1,32'h84,32'h99,       1'b0,1'b0,5'd0,32'h0,      1'b0,1'b0,1'b0,5'd1, 32'h99,      1'b0,32'h0};

    // Reset state, with a CPU store pending: no write may reach the RAM
    resetn = 1'b0;
    drive(1'b1, 1'b1, 32'h10, 32'hDEAD, 1'b1, 1'b1, 5'd2, 32'hF00D);
    #3;
    chk("rst_ram_we", bus.ram_we, 1'b0);
    chk("rst_rvalid", bus.dma_rvalid, 1'b0);
    chk("rst_rdata", bus.dma_rdata, 32'h0);
    @(posedge mem_clock); #1;
    resetn = 1'b1;

    // Single-cycle vector table
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].cpu_req, vecs[i].cpu_wmem, vecs[i].cpu_addr, vecs[i].cpu_wdata,
            vecs[i].dma_req, vecs[i].dma_we, vecs[i].dma_addr, vecs[i].dma_wdata);
      @(negedge mem_clock);
      chk($sformatf("vec%0d_gnt", i), bus.dma_gnt, vecs[i].e_gnt);
      chk($sformatf("vec%0d_stall", i), bus.cpu_stall, vecs[i].e_stall);
      chk($sformatf("vec%0d_ram_we", i), bus.ram_we, vecs[i].e_we);
      chk($sformatf("vec%0d_ram_addr", i), bus.ram_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_ram_wdata", i), bus.ram_wdata, vecs[i].e_wdata);
      if (vecs[i].e_rdchk) chk($sformatf("vec%0d_cpu_rdata", i), bus.cpu_rdata, vecs[i].e_rdata);
      @(posedge mem_clock); #1;
    end

    // Forced DMA slot: CPU loads every cycle, DMA read of word 3 held
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 5'd3, 32'h0);
    run_to_gnt("forced", n);
    chk("forced_gnt_cycle", n, 32'd4);
    chk("forced_ram_addr", bus.ram_addr, 5'd3);
    chk("forced_ram_we", bus.ram_we, 1'b0);
    @(posedge mem_clock); #1;
    bus.dma_req = 1'b0;
    @(negedge mem_clock);
    chk("forced_rvalid", bus.dma_rvalid, 1'b1);
    chk("forced_rdata", bus.dma_rdata, 32'hA5A5);
    chk("forced_stall_after", bus.cpu_stall, 1'b0);
    @(posedge mem_clock); #1;
    @(negedge mem_clock);
    chk("forced_rvalid_drop", bus.dma_rvalid, 1'b0);
    chk("forced_rdata_hold", bus.dma_rdata, 32'hA5A5);
    @(posedge mem_clock); #1;

    // Withdrawn request: two denied cycles, drop, re-raise needs full wait again
    drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 5'd5, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge mem_clock);
      chk("withdraw_denied_gnt", bus.dma_gnt, 1'b0);
      @(posedge mem_clock); #1;
    end
    bus.dma_req = 1'b0;
    @(negedge mem_clock);
    chk("withdraw_idle_gnt", bus.dma_gnt, 1'b0);
    @(posedge mem_clock); #1;
    bus.dma_req = 1'b1;
    run_to_gnt("reraise", n);
    chk("reraise_gnt_cycle", n, 32'd4);
    @(posedge mem_clock); #1;
    bus.dma_req = 1'b0;
    @(posedge mem_clock); #1;

    // Reset during the rd_pend cycle drops rvalid and clears held read data
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd3, 32'h0);
    @(negedge mem_clock);
    chk("rstmid_gnt", bus.dma_gnt, 1'b1);
    @(posedge mem_clock); #1;
    drive(1'b1, 1'b1, 32'h20, 32'hDEAD, 1'b1, 1'b0, 5'd3, 32'h0);
    @(negedge mem_clock);
    chk("rstmid_rvalid", bus.dma_rvalid, 1'b1);
    chk("rstmid_rdata", bus.dma_rdata, 32'hA5A5);
    chk("rstmid_cpu_we", bus.ram_we, 1'b1);
    chk("rstmid_denied", bus.dma_gnt, 1'b0);
    #1 resetn = 1'b0;
    #1;
    chk("rstmid_rvalid_drop", bus.dma_rvalid, 1'b0);
    chk("rstmid_rdata_clr", bus.dma_rdata, 32'h0);
    chk("rstmid_ram_we_gated", bus.ram_we, 1'b0);
    @(posedge mem_clock); #1;
    chk("rstmid_rvalid_held", bus.dma_rvalid, 1'b0);
    bus.cpu_wmem = 1'b0;
    resetn = 1'b1;
    run_to_gnt("postrst", n);
    chk("postrst_gnt_cycle", n, 32'd4);
    @(posedge mem_clock); #1;
    bus.dma_req = 1'b0;
    bus.cpu_req = 1'b0;
    @(negedge mem_clock);
    chk("postrst_rvalid", bus.dma_rvalid, 1'b1);
    chk("postrst_rdata", bus.dma_rdata, 32'hA5A5);
    @(posedge mem_clock); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
